npc_lsu: RTL

Multi-cycle load/store unit for the NPC core, parametrised for RV32/RV64. It replaces the single-cycle, word-only load path with full RISC-V load/store support: LB/LH/LW/LBU/LHU/SB/SH/SW, plus LD/LWU/SD when XLEN=64. It sits between the core's execute stage and the data-memory port, and talks to memory over a valid/ready request channel and a valid response channel. It aligns addresses, generates byte-write masks, performs load extraction with sign/zero extension, and detects misaligned or illegal accesses.

---
 rtl/npc_pkg.sv | 28 ++
 rtl/npc_lsu_align.sv | 65 ++++++
 rtl/npc_lsu.sv | 129 ++++++++++++
 3 files changed

// File: rtl/npc_pkg.sv
// Shared NPC core definitions: LSU FSM state encoding and load/store funct3 codes.
package npc_pkg;

   typedef enum logic [1:0] {
      LsuIdle,
      LsuReq,
      LsuWait,
      LsuResp
   } lsu_state_e;

   localparam logic [2:0] F3Lb  = 3'b000;
   localparam logic [2:0] F3Lh  = 3'b001;
   localparam logic [2:0] F3Lw  = 3'b010;
   localparam logic [2:0] F3Ld  = 3'b011;
   localparam logic [2:0] F3Lbu = 3'b100;
   localparam logic [2:0] F3Lhu = 3'b101;
   localparam logic [2:0] F3Lwu = 3'b110;
   localparam logic [2:0] F3Sb  = 3'b000;
   localparam logic [2:0] F3Sh  = 3'b001;
   localparam logic [2:0] F3Sw  = 3'b010;
   localparam logic [2:0] F3Sd  = 3'b011;

   // Access size in bytes from funct3[1:0].
   function automatic logic [3:0] size_bytes(input logic [1:0] size);
      return 4'd1 << size;
   endfunction

endpackage

// File: rtl/npc_lsu_align.sv
// Combinational lane logic for the LSU: store shift/mask, load extract/extend,
// and illegal/misaligned detection.
module npc_lsu_align
   import npc_pkg::*;
#(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned LANE_W = 2
) (
   input  logic [2:0]        funct3,
   input  logic [LANE_W-1:0] lane,
   input  logic              we,
   input  logic [XLEN-1:0]   wdata,
   input  logic [XLEN-1:0]   rdata,
   output logic [XLEN/8-1:0] wmask,
   output logic [XLEN-1:0]   wdata_sh,
   output logic [XLEN-1:0]   rdata_ext,
   output logic              err
);

   localparam int unsigned NBytes = XLEN / 8;

   logic [3:0]        nbytes;
   logic              illegal;
   logic              misaligned;
   logic [NBytes-1:0] base_mask;
   logic [XLEN-1:0]   rshift;
   logic [XLEN-1:0]   keep;
   logic              sign;

   always_comb begin
      nbytes  = size_bytes(funct3[1:0]);
      illegal = 1'b0;
      if (we) begin
         case (funct3)
            F3Sb, F3Sh, F3Sw: illegal = 1'b0;
            F3Sd:             illegal = (XLEN == 32);
            default:          illegal = 1'b1;
         endcase
      end else begin
         case (funct3)
            F3Lb, F3Lh, F3Lw, F3Lbu, F3Lhu: illegal = 1'b0;
            F3Ld, F3Lwu:                    illegal = (XLEN == 32);
            default:                        illegal = 1'b1;
         endcase
      end
      // Size is a power of two, so the low lane bits must be clear.
      misaligned = |(lane & LANE_W'(nbytes - 4'd1));
      err        = illegal | misaligned;
   end

   always_comb begin
      base_mask = NBytes'((16'd1 << nbytes) - 16'd1);
      wmask     = base_mask << lane;
      wdata_sh  = wdata << {lane, 3'b000};
   end

   // keep selects the access-size low bits; its top set bit marks the sign bit.
   always_comb begin
      rshift    = rdata >> {lane, 3'b000};
      keep      = ~({XLEN{1'b1}} << {nbytes, 3'b000});
      sign      = |(rshift & keep & ~(keep >> 1));
      rdata_ext = (rshift & keep) | ({XLEN{sign & ~funct3[2]}} & ~keep);
   end

endmodule

// File: rtl/npc_lsu.sv
// Multi-cycle load/store unit: IDLE -> REQ -> WAIT -> RESP, with an error
// shortcut from IDLE straight to RESP for illegal or misaligned accesses.
module npc_lsu
   import npc_pkg::*;
#(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              resp_valid,
   output logic [XLEN-1:0]   resp_rdata,
   output logic              resp_err,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   output logic [XLEN/8-1:0] mem_wmask,
   input  logic              mem_resp_valid,
   input  logic [XLEN-1:0]   mem_rdata
);

   localparam int unsigned NBytes = XLEN / 8;
   localparam int unsigned LaneW  = $clog2(NBytes);

   lsu_state_e        state;
   logic              we_q;
   logic [2:0]        funct3_q;
   logic [LaneW-1:0]  lane_q;

   logic              idle;
   logic [2:0]        a_funct3;
   logic [LaneW-1:0]  a_lane;
   logic              a_we;
   logic [NBytes-1:0] a_wmask;
   logic [XLEN-1:0]   a_wdata;
   logic [XLEN-1:0]   a_rdata;
   logic              a_err;

   assign idle      = (state == LsuIdle);
   assign req_ready = idle;

   // In IDLE the aligner judges the incoming request; later it extracts load data.
   assign a_funct3 = idle ? req_funct3 : funct3_q;
   assign a_lane   = idle ? req_addr[LaneW-1:0] : lane_q;
   assign a_we     = idle ? req_we : we_q;

   npc_lsu_align #(
      .XLEN   (XLEN),
      .LANE_W (LaneW)
   ) u_align (
      .funct3    (a_funct3),
      .lane      (a_lane),
      .we        (a_we),
      .wdata     (req_wdata),
      .rdata     (mem_rdata),
      .wmask     (a_wmask),
      .wdata_sh  (a_wdata),
      .rdata_ext (a_rdata),
      .err       (a_err)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state         <= LsuIdle;
         we_q          <= 1'b0;
         funct3_q      <= 3'b000;
         lane_q        <= '0;
         resp_valid    <= 1'b0;
         resp_rdata    <= '0;
         resp_err      <= 1'b0;
         mem_req_valid <= 1'b0;
         mem_we        <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         mem_wmask     <= '0;
      end else begin
         case (state)
            LsuIdle: begin
               if (req_valid) begin
                  we_q     <= req_we;
                  funct3_q <= req_funct3;
                  lane_q   <= req_addr[LaneW-1:0];
                  if (a_err) begin
                     state      <= LsuResp;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= '0;
                  end else begin
                     state         <= LsuReq;
                     mem_req_valid <= 1'b1;
                     mem_we        <= req_we;
                     mem_addr      <= req_addr & ~ADDR_W'(NBytes - 1);
                     mem_wdata     <= a_wdata;
                     mem_wmask     <= a_wmask;
                  end
               end
            end
            LsuReq: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  state         <= LsuWait;
               end
            end
            LsuWait: begin
               if (mem_resp_valid) begin
                  state      <= LsuResp;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b0;
                  resp_rdata <= we_q ? '0 : a_rdata;
               end
            end
            LsuResp: begin
               resp_valid <= 1'b0;
               state      <= LsuIdle;
            end
            default: state <= LsuIdle;
         endcase
      end
   end

endmodule
